adc_capture_buffer: RTL and testbench

- Sits directly downstream of the ADC sampling stage in the FPGA link emulator.
- Consumes each registered (time, signal) sample pair, waits for an arm/trigger condition and decimates the stream.
- Stores a bounded capture window in an on-chip FIFO.
- Presents stored samples to a readout consumer over a valid/ready handshake.

---
 rtl/adc_capture_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_adc_capture_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_buffer
// Description : Arms on request, triggers on a rising threshold crossing (or
//               a forced trigger), decimates the ADC sample stream and stores
//               a bounded capture window in a show-ahead FIFO drained over a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_buffer #(
    parameter int SIG_BITS   = 8,
    parameter int TIME_BITS  = 32,
    parameter int ADDR_BITS  = 6,
    parameter int DECIM_BITS = 8,
    parameter int LEN_BITS   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [TIME_BITS-1:0]        time_in,
    input  logic signed [SIG_BITS-1:0]  sig_in,
    input  logic                        arm,
    input  logic                        force_trig,
    input  logic                        abort,
    input  logic                        clear,
    input  logic signed [SIG_BITS-1:0]  thresh,
    input  logic [DECIM_BITS-1:0]       decim,
    input  logic [LEN_BITS-1:0]         capture_len,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TIME_BITS-1:0]        time_out,
    output logic signed [SIG_BITS-1:0]  sig_out,
    output logic [ADDR_BITS:0]          level,
    output logic                        overflow,
    output logic                        busy,
    output logic                        done
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_armed   = 2'd1;
    localparam logic [1:0] c_capture = 2'd2;
    localparam logic [1:0] c_done    = 2'd3;

    localparam int               c_depth_int = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] c_depth   = (ADDR_BITS+1)'(c_depth_int);

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic signed [SIG_BITS-1:0] r_prev_sig;
    logic                       r_prev_valid;
    logic                       r_force_pend;
    logic [DECIM_BITS-1:0]      r_decim_cnt;
    logic [DECIM_BITS-1:0]      w_decim_nxt;
    logic [LEN_BITS-1:0]        r_cap_cnt;
    logic [LEN_BITS-1:0]        w_cap_nxt;
    logic                       w_push_req;
    logic                       w_trig;
    logic                       w_enter_armed;
    logic [DECIM_BITS-1:0]      w_decim_eff;
    logic [DECIM_BITS:0]        w_decim_inc;
    logic [LEN_BITS:0]          w_cap_inc;

    logic [TIME_BITS-1:0]       r_mem_time [c_depth_int];
    logic [SIG_BITS-1:0]        r_mem_sig  [c_depth_int];
    logic [ADDR_BITS-1:0]       r_wr_ptr;
    logic [ADDR_BITS-1:0]       r_rd_ptr;
    logic [ADDR_BITS:0]         r_level;
    logic                       r_overflow;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_drop;

    // A decimation factor of zero behaves exactly like one.
    assign w_decim_eff = (decim == '0) ? DECIM_BITS'(1) : decim;
    assign w_decim_inc = {1'b0, r_decim_cnt} + 1'b1;
    assign w_cap_inc   = {1'b0, r_cap_cnt} + 1'b1;

    // A trigger needs a live sample; a force seen without one is held pending.
    assign w_trig = force_trig || r_force_pend ||
                    (r_prev_valid && (r_prev_sig < thresh) && (sig_in >= thresh));

    assign w_enter_armed = ((r_state == c_idle) || (r_state == c_done)) && arm && !abort;

    // Next-state, capture counters and FIFO write request.
    always_comb begin
        w_state_nxt = r_state;
        w_decim_nxt = r_decim_cnt;
        w_cap_nxt   = r_cap_cnt;
        w_push_req  = 1'b0;
        case (r_state)
            c_idle, c_done: begin
                if (arm) begin
                    w_state_nxt = c_armed;
                end
            end
            c_armed: begin
                if (in_valid && w_trig) begin
                    if (capture_len == '0) begin
                        w_state_nxt = c_done;
                    end else begin
                        w_push_req  = 1'b1;
                        w_cap_nxt   = LEN_BITS'(1);
                        w_decim_nxt = (w_decim_eff == DECIM_BITS'(1)) ? '0 : DECIM_BITS'(1);
                        w_state_nxt = (capture_len == LEN_BITS'(1)) ? c_done : c_capture;
                    end
                end
            end
            c_capture: begin
                if (in_valid) begin
                    // >= keeps the wrap safe if decim shrinks mid-capture
                    w_decim_nxt = (w_decim_inc >= {1'b0, w_decim_eff}) ? '0
                                                                       : w_decim_inc[DECIM_BITS-1:0];
                    if (r_decim_cnt == '0) begin
                        w_push_req = 1'b1;
                        w_cap_nxt  = w_cap_inc[LEN_BITS-1:0];
                        if (w_cap_inc >= {1'b0, capture_len}) begin
                            w_state_nxt = c_done;
                        end
                    end
                end
            end
            default: w_state_nxt = c_idle;
        endcase
        if (abort) begin
            w_state_nxt = c_idle;
            w_push_req  = 1'b0;
        end
    end

    // Capture control state, counters and previous-sample tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_decim_cnt  <= '0;
            r_cap_cnt    <= '0;
            r_prev_sig   <= '0;
            r_prev_valid <= 1'b0;
            r_force_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_decim_cnt <= w_decim_nxt;
            r_cap_cnt   <= w_cap_nxt;
            if (w_enter_armed) begin
                r_prev_valid <= 1'b0;
            end else if ((r_state == c_armed) && in_valid) begin
                r_prev_valid <= 1'b1;
                r_prev_sig   <= sig_in;
            end
            r_force_pend <= (r_state == c_armed) && (w_state_nxt == c_armed) &&
                            (r_force_pend || (force_trig && !in_valid));
        end
    end

    assign w_full = (r_level == c_depth);
    assign w_pop  = out_valid && out_ready;
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && w_full && !w_pop;

    // FIFO pointers, occupancy and sticky overflow; clear overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; no reset needed since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem_time[r_wr_ptr] <= time_in;
            r_mem_sig[r_wr_ptr]  <= sig_in;
        end
    end

    assign out_valid = (r_level != '0);
    assign time_out  = out_valid ? r_mem_time[r_rd_ptr] : '0;
    assign sig_out   = out_valid ? r_mem_sig[r_rd_ptr]  : '0;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign busy      = (r_state == c_armed) || (r_state == c_capture);
    assign done      = (r_state == c_done);

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture_buffer
// Description : Directed self-checking bench for adc_capture_buffer with a
//               4-entry FIFO; expected values are hand-computed per step.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_capture_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] time_in;
    logic [7:0]  sig_in;
    logic        arm;
    logic        force_trig;
    logic        abort;
    logic        clear;
    logic [7:0]  thresh;
    logic [7:0]  decim;
    logic [15:0] capture_len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] time_out;
    logic [7:0]  sig_out;
    logic [2:0]  level;
    logic        overflow;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    adc_capture_buffer #(
        .SIG_BITS   (8),
        .TIME_BITS  (32),
        .ADDR_BITS  (2),
        .DECIM_BITS (8),
        .LEN_BITS   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .time_in     (time_in),
        .sig_in      (sig_in),
        .arm         (arm),
        .force_trig  (force_trig),
        .abort       (abort),
        .clear       (clear),
        .thresh      (thresh),
        .decim       (decim),
        .capture_len (capture_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .time_out    (time_out),
        .sig_out     (sig_out),
        .level       (level),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then drop all single-cycle pulses.
    task automatic step();
        @(posedge clk);
        #1;
        arm        = 1'b0;
        force_trig = 1'b0;
        abort      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
    endtask

    task automatic samp(input logic [31:0] t, input logic [7:0] s);
        in_valid = 1'b1;
        time_in  = t;
        sig_in   = s;
        step();
    endtask

    // Check the FIFO head, then pop it in one handshake cycle.
    task automatic rd_expect(input string tag, input logic [31:0] t, input logic [7:0] s);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_time"}, time_out, t);
        chk({tag, "_sig"}, {24'd0, sig_out}, {24'd0, s});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; time_in = '0; sig_in = '0;
        arm = 1'b0; force_trig = 1'b0; abort = 1'b0; clear = 1'b0;
        thresh = 8'd10; decim = 8'd1; capture_len = 16'd3; out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_time", time_out, 32'd0);
        chk("rst_sig", {24'd0, sig_out}, 32'd0);
        rst_n = 1'b1;
        step();

        // Threshold trigger: 3,8,12,15,20 with thresh 10 stores 12,15,20
        arm = 1'b1; step();
        chk("thr_busy", {31'd0, busy}, 32'd1);
        samp(32'd100, 8'd3);
        samp(32'd101, 8'd8);
        chk("thr_notrig", {29'd0, level}, 32'd0);
        samp(32'd102, 8'd12);
        chk("thr_lvl1", {29'd0, level}, 32'd1);
        chk("thr_head", {24'd0, sig_out}, 32'd12);
        samp(32'd103, 8'd15);
        chk("thr_notdone", {31'd0, done}, 32'd0);
        samp(32'd104, 8'd20);
        chk("thr_done", {31'd0, done}, 32'd1);
        chk("thr_lvl3", {29'd0, level}, 32'd3);
        rd_expect("thr_r0", 32'd102, 8'd12);
        rd_expect("thr_r1", 32'd103, 8'd15);
        rd_expect("thr_r2", 32'd104, 8'd20);
        chk("thr_empty", {31'd0, out_valid}, 32'd0);

        // Decimation by 4 over samples 0..11 stores 0,4,8
        decim = 8'd4; capture_len = 16'd3;
        arm = 1'b1; step();
        for (int i = 0; i < 12; i++) begin
            force_trig = (i == 0);
            samp(32'(200 + i), 8'(i));
        end
        chk("dec_lvl", {29'd0, level}, 32'd3);
        chk("dec_done", {31'd0, done}, 32'd1);
        rd_expect("dec_r0", 32'd200, 8'd0);
        rd_expect("dec_r1", 32'd204, 8'd4);
        rd_expect("dec_r2", 32'd208, 8'd8);

        // decim=0 acts as 1; force without a sample triggers on the next one
        decim = 8'd0; capture_len = 16'd2;
        arm = 1'b1; step();
        force_trig = 1'b1; step();
        chk("d0_pend_lvl", {29'd0, level}, 32'd0);
        chk("d0_pend_busy", {31'd0, busy}, 32'd1);
        samp(32'd300, 8'd50);
        samp(32'd301, 8'd51);
        samp(32'd302, 8'd52);
        chk("d0_done", {31'd0, done}, 32'd1);
        chk("d0_lvl", {29'd0, level}, 32'd2);
        rd_expect("d0_r0", 32'd300, 8'd50);
        rd_expect("d0_r1", 32'd301, 8'd51);

        // capture_len 0: trigger goes straight to DONE without writing
        decim = 8'd1; capture_len = 16'd0;
        arm = 1'b1; step();
        force_trig = 1'b1;
        samp(32'd400, 8'd1);
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_lvl", {29'd0, level}, 32'd0);

        // Overflow: 6 samples into a 4-entry FIFO with no readout
        capture_len = 16'd6;
        arm = 1'b1; step();
        for (int i = 0; i < 6; i++) begin
            force_trig = (i == 0);
            samp(32'(500 + i), 8'(30 + i));
        end
        chk("ovf_lvl", {29'd0, level}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_done", {31'd0, done}, 32'd1);
        step();
        chk("ovf_stall_sig", {24'd0, sig_out}, 32'd30);
        chk("ovf_stall_time", time_out, 32'd500);
        rd_expect("ovf_r0", 32'd500, 8'd30);
        step();
        chk("ovf_stall2", {24'd0, sig_out}, 32'd31);
        rd_expect("ovf_r1", 32'd501, 8'd31);
        rd_expect("ovf_r2", 32'd502, 8'd32);
        rd_expect("ovf_r3", 32'd503, 8'd33);
        chk("ovf_empty", {31'd0, out_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        clear = 1'b1; step();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with simultaneous push and pop
        capture_len = 16'd5;
        arm = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            force_trig = (i == 0);
            samp(32'(600 + i), 8'(40 + i));
        end
        chk("fp_full", {29'd0, level}, 32'd4);
        out_ready = 1'b1;
        samp(32'd604, 8'd44);
        out_ready = 1'b0;
        chk("fp_lvl", {29'd0, level}, 32'd4);
        chk("fp_ovf", {31'd0, overflow}, 32'd0);
        chk("fp_done", {31'd0, done}, 32'd1);
        rd_expect("fp_r0", 32'd601, 8'd41);
        rd_expect("fp_r1", 32'd602, 8'd42);
        rd_expect("fp_r2", 32'd603, 8'd43);
        rd_expect("fp_r3", 32'd604, 8'd44);

        // Signed threshold crossing, then abort with data retained
        thresh = -8'sd5; capture_len = 16'd10;
        arm = 1'b1; step();
        samp(32'd700, -8'sd10);
        samp(32'd701, -8'sd3);
        samp(32'd702, -8'sd1);
        chk("ab_lvl", {29'd0, level}, 32'd2);
        chk("ab_head", {24'd0, sig_out}, {24'd0, 8'hFD});
        chk("ab_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        samp(32'd703, -8'sd2);
        chk("ab_idle_busy", {31'd0, busy}, 32'd0);
        chk("ab_idle_done", {31'd0, done}, 32'd0);
        chk("ab_kept", {29'd0, level}, 32'd2);

        // clear on the same edge as a push discards that push
        arm = 1'b1; step();
        force_trig = 1'b1; clear = 1'b1;
        samp(32'd710, 8'd70);
        chk("clr_lvl", {29'd0, level}, 32'd0);
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        samp(32'd711, 8'd71);
        chk("clr_lvl1", {29'd0, level}, 32'd1);
        chk("clr_head_sig", {24'd0, sig_out}, 32'd71);
        chk("clr_head_time", time_out, 32'd711);
        abort = 1'b1; step();

        // Asynchronous reset in the middle of a capture
        thresh = 8'd10; capture_len = 16'd10;
        clear = 1'b1; step();
        arm = 1'b1; step();
        for (int i = 0; i < 6; i++) begin
            force_trig = (i == 0);
            samp(32'(800 + i), 8'(80 + i));
        end
        chk("ar_pre_lvl", {29'd0, level}, 32'd4);
        chk("ar_pre_ovf", {31'd0, overflow}, 32'd1);
        chk("ar_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_lvl", {29'd0, level}, 32'd0);
        chk("ar_ovf", {31'd0, overflow}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        #3;
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
